spart_rx_fifo: RTL and testbench
================================

Name: spart_rx_fifo

Overview:
- Buffered receive front-end between the SPART receive shifter and the shared 32-bit memory-mapped bus. It is read by the bootloader during program load and by the cpu afterwards.
- Captures received bytes into a FIFO and exposes them through four bus registers: byte pop, little-endian word pop, status, and control.
- Word pop returns instruction words in the byte order the host sends them (LSB first), so the bootloader can fetch one instruction per bus transaction.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, at least 4.
- BASE_ADDR, 32'h0000_0100, bus base address; the register block spans BASE_ADDR..BASE_ADDR+0xF.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- rx_data_i  in  8  received byte from the SPART receiver.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid this cycle.
- addr_i  in  32  bus address.
- data_i  in  32  bus write data.
- read_i  in  1  bus read request; level, held by the master until ack.
- write_i  in  1  bus write request; level, held by the master until ack.
- data_o  out  32  bus read data; forced to 0 whenever ack_o is low, so it can be OR-combined on the shared bus.
- ack_o  out  1  one-cycle transaction acknowledge.
- rx_avail_o  out  1  high when FIFO count is nonzero (interrupt/poll hint).

Behaviour:
- Reset: FIFO empty, count=0, rd/wr pointers=0, overflow=0, FSM=IDLE, data_o=0, ack_o=0, rx_avail_o=0.
- Register map (offset = addr_i - BASE_ADDR; only bits [3:2] are decoded, bits [1:0] ignored):
  - 0x0 DATA, R: pops 1 byte, returns {24'h0, byte}. If empty, returns 0 and does not pop.
  - 0x4 STATUS, R: returns {16'h0, count[7:0], 5'h0, overflow, word_avail(count>=4), byte_avail(count>=1)}. No side effects.
  - 0x8 WORD, R: if count>=4, pops 4 bytes and returns {b3,b2,b1,b0} where b0 is the oldest byte. If count<4, returns 0 and does not pop.
  - 0xC CTRL, W: bit0=1 flushes the FIFO (pointers and count to 0); bit1=1 clears overflow. Reads of 0xC return 0.
  - Writes to 0x0, 0x4 and 0x8 are acknowledged and ignored.
- Address match: addr_i[31:4] == BASE_ADDR[31:4]. Requests outside the block are never acknowledged or driven.
- Bus FSM:
  - IDLE: a matching read_i or write_i goes to RESP.
  - RESP (1 cycle): ack_o=1; data_o holds the register value sampled this cycle; pop, flush or clear takes effect at this clock edge. Goes to DROP.
  - DROP: ack_o=0; waits until read_i and write_i are both low, then goes to IDLE. This guarantees exactly one pop per transaction even if the master holds its request an extra cycle.
  - Latency: ack_o one cycle after the request is first sampled.
  - read_i and write_i high together: treated as a read.
- FIFO push: rx_valid_i writes rx_data_i at wr_ptr, unless full with no pop that cycle.
  - In that case the byte is dropped and overflow is set (sticky).
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Simultaneous events in the same cycle:
  - Push and byte pop: count unchanged; accepted even when full.
  - Push and word pop: count = count - 4 + 1.
  - Push and flush: flush wins; the pushed byte is discarded, count=0, overflow is not set.
  - Overflow-set and overflow-clear: set wins.
- Data returned by a pop in RESP uses FIFO contents as of the start of that cycle. A same-cycle push is never visible to the same-cycle pop, including when the FIFO is empty.
- rx_avail_o = (count != 0), registered-state combinational with no extra latency.
- Reset asserted mid-transaction: immediate return to the reset state. ack_o drops asynchronously and FIFO contents are lost.

Test Plan:
- Push bytes 93,00,C0,01 on four rx_valid_i strobes, then read 0x8 -> ack after 1 cycle, data_o=32'h01C00093. A following STATUS read returns 32'h0000_0000.
- Push 3 bytes, then read WORD -> data_o=0 and count stays 3 (STATUS=32'h0000_0301). Read DATA three times -> oldest-first bytes; a fourth DATA read returns 0.
- Push 17 bytes with DEPTH=16 -> STATUS=32'h0000_1007. Fourteen DATA reads return bytes 1..14 (byte 17 dropped). Write 0xC=2 -> overflow clears and STATUS reflects 2 remaining bytes.
- Master holds read_i for 4 cycles on DATA with 2 bytes queued -> a single ack pulse and exactly one byte popped; a new read after read_i drops returns the second byte.
- Fill to 16, then assert rx_valid_i in the same cycle as a DATA RESP -> count stays 16, overflow=0, and the new byte is the last one read out.
- Write 0xC=1 with 9 bytes queued and a simultaneous rx_valid_i -> count=0, rx_avail_o=0, overflow=0. Assert rst_n low during RESP -> ack_o=0 immediately and STATUS=0 afterwards.

Source files
------------

// File: rtl/spart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spart_rx_fifo
// Purpose  : Buffered receive front-end for the SPART. Received bytes are
//            queued in a FIFO and read over the 32-bit memory-mapped bus
//            through four registers: DATA (byte pop), STATUS, WORD
//            (little-endian 4-byte pop) and CTRL (flush / clear overflow).
// Ports    : clk, rst_n          - clock, async active-low reset
//            rx_data_i/rx_valid_i - byte strobe from the receive shifter
//            addr_i/data_i        - bus address / write data
//            read_i/write_i       - level requests, held until ack
//            data_o/ack_o         - read data (0 when not acking) / ack pulse
//            rx_avail_o           - FIFO non-empty hint
// Revision : 1.0 - initial release
// ============================================================================
module spart_rx_fifo #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        read_i,
  input  logic        write_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        rx_avail_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_resp = 2'd1;
  localparam logic [1:0] c_st_drop = 2'd2;

  localparam logic [1:0] c_reg_data   = 2'd0;
  localparam logic [1:0] c_reg_status = 2'd1;
  localparam logic [1:0] c_reg_word   = 2'd2;

  logic [1:0]    r_state;
  logic          r_is_read;
  logic [1:0]    r_reg;
  logic [1:0]    r_wdata;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [7:0]    r_mem [DEPTH];

  logic          w_match;
  logic          w_resp;
  logic          w_byte_avail;
  logic          w_word_avail;
  logic          w_full;
  logic          w_byte_pop;
  logic          w_word_pop;
  logic          w_flush;
  logic          w_ovf_clr;
  logic          w_push;
  logic          w_ovf_set;
  logic [31:0]   w_word;
  logic [31:0]   w_cnt32;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Bits of the bus that the register block never decodes.
  assign w_unused = ^{addr_i[1:0], data_i[31:2]};

  assign w_match      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_resp       = (r_state == c_st_resp);
  assign w_byte_avail = (r_count != '0);
  assign w_word_avail = (r_count >= CW'(4));
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_cnt32      = 32'(r_count);

  // All side effects land on the clock edge that ends the RESP cycle.
  assign w_byte_pop = w_resp && r_is_read && (r_reg == c_reg_data) && w_byte_avail;
  assign w_word_pop = w_resp && r_is_read && (r_reg == c_reg_word) && w_word_avail;
  assign w_flush    = w_resp && !r_is_read && (r_reg == 2'd3) && r_wdata[0];
  assign w_ovf_clr  = w_resp && !r_is_read && (r_reg == 2'd3) && r_wdata[1];

  // A pop in the same cycle frees space, so a push into a full FIFO is
  // accepted then. Flush swallows any same-cycle byte without flagging it.
  assign w_push    = rx_valid_i && !w_flush && (!w_full || w_byte_pop || w_word_pop);
  assign w_ovf_set = rx_valid_i && !w_flush && w_full && !w_byte_pop && !w_word_pop;

  // Four consecutive bytes starting at the read pointer, oldest in the LSB.
  for (genvar k = 0; k < 4; k++) begin : g_word_bytes
    assign w_word[8*k +: 8] = r_mem[r_rd_ptr + AW'(k)];
  end

  always_comb begin
    w_rdata = 32'h0;
    if (r_is_read) begin
      case (r_reg)
        c_reg_data:   w_rdata = w_byte_avail ? {24'h0, r_mem[r_rd_ptr]} : 32'h0;
        c_reg_status: w_rdata = {16'h0, w_cnt32[7:0], 5'h0, r_ovf, w_word_avail, w_byte_avail};
        c_reg_word:   w_rdata = w_word_avail ? w_word : 32'h0;
        default:      w_rdata = 32'h0;
      endcase
    end
  end

  assign ack_o      = w_resp;
  assign data_o     = w_resp ? w_rdata : 32'h0;
  assign rx_avail_o = w_byte_avail;

  // Bus handshake: one RESP cycle per request, then DROP until the master
  // releases so a held request cannot pop twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_is_read <= 1'b0;
      r_reg     <= 2'd0;
      r_wdata   <= 2'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_match && (read_i || write_i)) begin
            r_state   <= c_st_resp;
            r_is_read <= read_i;
            r_reg     <= addr_i[3:2];
            r_wdata   <= data_i[1:0];
          end
        end
        c_st_resp: r_state <= c_st_drop;
        c_st_drop: begin
          if (!read_i && !write_i) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_byte_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end else if (w_word_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(4);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_byte_pop)
                 - (w_word_pop ? CW'(4) : CW'(0));
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Storage needs no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_spart_rx_fifo
// Purpose  : Directed self-checking bench for spart_rx_fifo with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spart_rx_fifo;

  localparam logic [31:0] c_base = 32'h0000_0100;
  localparam logic [31:0] c_data = c_base + 32'h0;
  localparam logic [31:0] c_stat = c_base + 32'h4;
  localparam logic [31:0] c_word = c_base + 32'h8;
  localparam logic [31:0] c_ctrl = c_base + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] data_o;
  logic        ack_o;
  logic        rx_avail_o;

  int checks = 0;
  int errors = 0;

  spart_rx_fifo #(.DEPTH(16), .BASE_ADDR(c_base)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .addr_i     (addr),
    .data_i     (wdata),
    .read_i     (rd),
    .write_i    (wr),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .rx_avail_o (rx_avail_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic bus(input bit is_wr, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rdata, output int lat);
    addr  = a;
    wdata = wd;
    rd    = !is_wr;
    wr    = is_wr;
    lat   = 0;
    rdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        lat   = i;
        rdata = data_o;
        break;
      end
    end
    if (lat == 0) check("ack_timeout", 32'h0, 32'h1);
    rd = 1'b0;
    wr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    int          l;
    bus(1'b0, a, 32'h0, v, l);
    check(tag, v, exp);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] v;
    int          l;
    bus(1'b1, a, wd, v, l);
  endtask

  initial begin
    logic [31:0] v;
    int          l;
    int          acks;

    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_ack", {31'h0, ack_o}, 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_avail", {31'h0, rx_avail_o}, 32'h0);
    rd_chk("rst_status", c_stat, 32'h0);

    // Instruction word assembled LSB first
    push(8'h93); push(8'h00); push(8'hC0); push(8'h01);
    check("avail4", {31'h0, rx_avail_o}, 32'h1);
    bus(1'b0, c_word, 32'h0, v, l);
    check("word_lat", l, 32'd1);
    check("word_val", v, 32'h01C0_0093);
    rd_chk("word_status_after", c_stat, 32'h0);

    // Word pop refused below 4 bytes; byte pops oldest-first
    push(8'h11); push(8'h22); push(8'h33);
    rd_chk("word_short", c_word, 32'h0);
    rd_chk("status3", c_stat, 32'h0000_0301);
    rd_chk("byte0", c_data, 32'h11);
    rd_chk("byte1", c_data, 32'h22);
    rd_chk("byte2", c_data, 32'h33);
    rd_chk("byte_empty", c_data, 32'h0);
    rd_chk("ctrl_read", c_ctrl, 32'h0);

    // Overflow: 17 pushes into 16 slots
    for (int i = 1; i <= 17; i++) push(8'(i));
    rd_chk("status_ovf", c_stat, 32'h0000_1007);
    for (int i = 1; i <= 14; i++) rd_chk("ovf_byte", c_data, 32'(i));
    wr_reg(c_ctrl, 32'h2);
    rd_chk("ovf_cleared", c_stat, 32'h0000_0201);
    rd_chk("ovf_byte15", c_data, 32'd15);
    rd_chk("ovf_byte16", c_data, 32'd16);
    rd_chk("ovf_empty", c_stat, 32'h0);

    // Held request produces one ack and one pop
    push(8'hA1); push(8'hA2);
    addr = c_data;
    rd   = 1'b1;
    acks = 0;
    v    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        acks++;
        v = data_o;
      end
    end
    rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_acks", acks, 32'd1);
    check("hold_data", v, 32'hA1);
    rd_chk("hold_status", c_stat, 32'h0000_0101);
    rd_chk("hold_second", c_data, 32'hA2);

    // Full FIFO: push in the same cycle as a byte pop is accepted
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    addr = c_data;
    rd   = 1'b1;
    @(posedge clk); #1;
    check("full_resp_ack", {31'h0, ack_o}, 32'h1);
    check("full_resp_data", data_o, 32'h40);
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rd       = 1'b0;
    @(posedge clk); #1;
    rd_chk("full_status", c_stat, 32'h0000_1003);
    for (int i = 1; i < 16; i++) rd_chk("full_byte", c_data, 32'h40 + 32'(i));
    rd_chk("full_last", c_data, 32'hEE);

    // Flush beats a same-cycle push
    for (int i = 0; i < 9; i++) push(8'h70 + 8'(i));
    addr  = c_ctrl;
    wdata = 32'h1;
    wr    = 1'b1;
    @(posedge clk); #1;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    wr       = 1'b0;
    @(posedge clk); #1;
    check("flush_avail", {31'h0, rx_avail_o}, 32'h0);
    rd_chk("flush_status", c_stat, 32'h0);

    // Reset during RESP
    push(8'h01); push(8'h02);
    addr = c_data;
    rd   = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack_before", {31'h0, ack_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", {31'h0, ack_o}, 32'h0);
    check("rst_mid_data", data_o, 32'h0);
    rd = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_avail", {31'h0, rx_avail_o}, 32'h0);
    rd_chk("rst_mid_status", c_stat, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
